multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. It is the driver of the 2-bit aluOp
//  bus decoded by the ALU control decoder:
//   00 add | 01 sub | 10 use funct | 11 use immediate opcode (andi/ori/xori).
//  It sequences fetch/decode/execute/memory/writeback, handshakes with variable-latency
//  memory, and flags illegal opcodes and memory timeouts.
// PARAMETERS
//  TIMEOUT     255  max cycles a memory state waits for memReady before aborting
//  CNT_WIDTH   8    width of wait counter; must satisfy 2**CNT_WIDTH > TIMEOUT
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  opcode       in   6  IR[31:26]; stable from DECODE until the next FETCH
//  memReady     in   1  memory completes the current read/write this cycle
//  pcWrite      out  1  unconditional PC load
//  pcWriteCond  out  1  PC load if ALU zero (beq)
//  iorD         out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
//  memRead      out  1  memory read request; held until memReady
//  memWrite     out  1  memory write request; held until memReady
//  irWrite      out  1  IR load
//  memToReg     out  1  1 = writeback from MDR, 0 = from ALUOut
//  regDst       out  1  1 = rd, 0 = rt
//  regWrite     out  1  register file write
//  aluSrcA      out  1  0 = PC, 1 = regA
//  aluSrcB      out  2  00 regB | 01 const 4 | 10 signext imm | 11 signext imm<<2
//  aluOp        out  2  to the ALU control decoder, encoding as above
//  pcSource     out  2  00 ALU result | 01 ALUOut | 10 jump target
//  instrDone    out  1  one-cycle pulse when an instruction retires
//  illegalOp    out  1  one-cycle pulse, unknown opcode in DECODE
//  busError     out  1  one-cycle pulse, memory wait timed out
//  state        out  4  current state code, for debug
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE; waitCnt=0.
//    - All outputs are 0, including the pulses (all are registered).
//  - Control outputs are Moore, decoded from the registered state.
//    - Exceptions: irWrite and pcWrite in FETCH are gated by memReady.
//  - IDLE(0): all outputs 0 -> FETCH the next cycle.
//  - FETCH(1): memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
//    - On memReady: irWrite=1, pcWrite=1, go to DECODE.
//  - DECODE(2): aluSrcA=0, aluSrcB=11, aluOp=00 (precompute branch target). Next state by opcode:
//    - 000000 -> R_EXEC
//    - 100011 / 101011 -> MEM_ADDR
//    - 000100 -> BRANCH
//    - 000010 -> JUMP
//    - 001000 / 001100 / 001101 / 001110 -> I_EXEC
//    - any other opcode -> FETCH, with illegalOp=1 for one cycle.
//  - MEM_ADDR(3): aluSrcA=1, aluSrcB=10, aluOp=00.
//    - lw -> MEM_READ; sw -> MEM_WRITE.
//  - MEM_READ(4): memRead=1, iorD=1. Stays until memReady, then MEM_WB.
//  - MEM_WB(5): regWrite=1, memToReg=1, regDst=0 -> FETCH.
//  - MEM_WRITE(6): memWrite=1, iorD=1. Stays until memReady, then FETCH.
//  - R_EXEC(7): aluSrcA=1, aluSrcB=00, aluOp=10 -> R_WB.
//  - R_WB(8): regWrite=1, regDst=1, memToReg=0 -> FETCH.
//  - I_EXEC(9): aluSrcA=1, aluSrcB=10 -> I_WB.
//    - aluOp=00 for addi; aluOp=11 for andi/ori/xori.
//  - I_WB(10): regWrite=1, regDst=0, memToReg=0 -> FETCH.
//  - BRANCH(11): aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01 -> FETCH.
//  - JUMP(12): pcWrite=1, pcSource=10 -> FETCH.
//  - Unused codes 13-15 -> IDLE; all outputs 0.
//  - instrDone: asserted in the cycle after leaving MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH or JUMP.
//    - Not asserted after an illegalOp or busError abort.
//  - Wait counter (FETCH, MEM_READ, MEM_WRITE):
//    - waitCnt clears on entry to the state.
//    - It increments each cycle memReady=0.
//    - If waitCnt==TIMEOUT-1 and memReady=0: go to FETCH, busError=1 for one cycle, no PC/IR/reg write.
//    - If memReady=1 in that same cycle, memReady wins and no error is raised.
//  - While waiting, the request and address controls are held constant.
//  - Reset mid-instruction: immediate return to IDLE; in-flight request is dropped.
//  - Latency with memReady tied high:
//    - lw 5 cycles; sw, R-type and I-type 4 cycles; beq and j 3 cycles.
// TESTING
//  - Reset, memReady=1, opcode=000000:
//    - state sequence IDLE, FETCH, DECODE, R_EXEC(aluOp=10), R_WB(regWrite=1, regDst=1), FETCH.
//    - instrDone pulses once.
//  - opcode=001101 (ori):
//    - I_EXEC drives aluOp=11, aluSrcB=10.
//    - I_WB drives regWrite=1, regDst=0.
//  - opcode=100011 with memReady low 3 cycles in MEM_READ:
//    - memRead=1 and iorD=1 held for 4 cycles, then MEM_WB with memToReg=1.
//  - opcode=000100: BRANCH drives aluOp=01, pcWriteCond=1, pcSource=01.
//    - opcode=111111 instead: illegalOp pulse and return to FETCH, no instrDone.
//  - Timeout: TIMEOUT=4, memReady=0 forever in FETCH:
//    - busError after 4 cycles; irWrite and pcWrite stay 0; FETCH re-entered.
//    - memReady=1 on the 4th cycle instead: no busError.
//  - rst_n low during MEM_WRITE with memWrite=1:
//    - all outputs 0 asynchronously, before the next clock edge.
//    - state=IDLE; FETCH follows after rst_n deasserts.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS datapath, with
// variable-latency memory handshake, illegal-opcode and memory-timeout detection.
module multicycle_control #(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       instrDone,
  output logic       illegalOp,
  output logic       busError,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_READ = 4'd4,
    MEM_WB = 4'd5, MEM_WRITE = 4'd6, R_EXEC = 4'd7, R_WB = 4'd8, I_EXEC = 4'd9,
    I_WB = 4'd10, BRANCH = 4'd11, JUMP = 4'd12
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
    OP_ORI = 6'b001101, OP_XORI = 6'b001110;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic instr_done_q, instr_done_d, illegal_op_q, illegal_op_d, bus_error_q, bus_error_d;
  logic waiting, timeout;
  always_comb begin
    waiting = state_q inside {FETCH, MEM_READ, MEM_WRITE};
    timeout = waiting && !memReady && wait_cnt_q == CNT_WIDTH'(TIMEOUT - 1);
    // Counter is zero outside wait states, so every entry into one starts from zero
    wait_cnt_d = (waiting && !memReady && !timeout) ? wait_cnt_q + CNT_WIDTH'(1) : '0;
    illegal_op_d = 1'b0;
    bus_error_d = timeout;
    instr_done_d = (state_q inside {MEM_WB, R_WB, I_WB, BRANCH, JUMP}) ||
                   (state_q == MEM_WRITE && memReady);
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = FETCH;
      FETCH:     state_d = memReady ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_R:                              state_d = R_EXEC;
          OP_LW, OP_SW:                      state_d = MEM_ADDR;
          OP_BEQ:                            state_d = BRANCH;
          OP_J:                              state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = I_EXEC;
          default: begin
            state_d = FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      MEM_ADDR:  state_d = opcode == OP_SW ? MEM_WRITE : MEM_READ;
      MEM_READ:  state_d = memReady ? MEM_WB : timeout ? FETCH : MEM_READ;
      MEM_WRITE: state_d = (memReady || timeout) ? FETCH : MEM_WRITE;
      R_EXEC:    state_d = R_WB;
      I_EXEC:    state_d = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_d = FETCH;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      instr_done_q <= 1'b0;
      illegal_op_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      instr_done_q <= instr_done_d;
      illegal_op_q <= illegal_op_d;
      bus_error_q  <= bus_error_d;
    end
  end
  // Moore decode; only the FETCH IR/PC loads look at memReady
  always_comb begin
    {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite, aluSrcA} = '0;
    aluSrcB = 2'b00;
    aluOp = 2'b00;
    pcSource = 2'b00;
    case (state_q)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
      end
      DECODE:    aluSrcB = 2'b11;
      MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      MEM_READ: begin
        memRead = 1'b1;
        iorD = 1'b1;
      end
      MEM_WB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      MEM_WRITE: begin
        memWrite = 1'b1;
        iorD = 1'b1;
      end
      R_EXEC: begin
        aluSrcA = 1'b1;
        aluOp = 2'b10;
      end
      R_WB: begin
        regWrite = 1'b1;
        regDst = 1'b1;
      end
      I_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        aluOp = opcode == OP_ADDI ? 2'b00 : 2'b11;
      end
      I_WB:      regWrite = 1'b1;
      BRANCH: begin
        aluSrcA = 1'b1;
        aluOp = 2'b01;
        pcWriteCond = 1'b1;
        pcSource = 2'b01;
      end
      JUMP: begin
        pcWrite = 1'b1;
        pcSource = 2'b10;
      end
      default: ;
    endcase
  end
  assign state     = state_q;
  assign instrDone = instr_done_q;
  assign illegalOp = illegal_op_q;
  assign busError  = bus_error_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed stimulus for the multicycle control FSM, checked every
// cycle against a path-per-instruction model plus hand-computed literal expectations.
module tb_multicycle_control;
  localparam int TO = 4;
  logic clk = 1'b0, rst_n = 1'b0, memReady = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic instrDone, illegalOp, busError;
  logic [3:0] state;
  logic [15:0] ctl;
  int tests = 0, fails = 0;

  multicycle_control #(.TIMEOUT(TO), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .instrDone(instrDone), .illegalOp(illegalOp),
    .busError(busError), .state(state)
  );

  always #5 clk = ~clk;
  assign ctl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst,
                regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  // Remaining state path after DECODE, one nibble per step, 0 terminates
  function automatic logic [11:0] route(input logic [5:0] op);
    case (op)
      6'b100011: return {4'd3, 4'd4, 4'd5};
      6'b101011: return {4'd3, 4'd6, 4'd0};
      6'b000000: return {4'd7, 4'd8, 4'd0};
      6'b001000, 6'b001100, 6'b001101, 6'b001110: return {4'd9, 4'd10, 4'd0};
      6'b000100: return {4'd11, 8'd0};
      6'b000010: return {4'd12, 8'd0};
      default:   return 12'd0;
    endcase
  endfunction

  function automatic logic [3:0] head(input logic [11:0] r);
    return r[11:8];
  endfunction

  // {pw, pwc, iorD, mRd, mWr, irW, m2r, rDst, rW, srcA, srcB, aluOp, pcSrc}
  function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr, input logic [5:0] op);
    case (st)
      4'd1:  return {mr, 2'b00, 1'b1, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 2'b00};
      4'd2:  return {6'b0, 4'b0000, 2'b11, 4'b0};
      4'd3:  return {6'b0, 4'b0001, 2'b10, 4'b0};
      4'd4:  return {6'b001100, 10'b0};
      4'd5:  return {6'b0, 4'b1010, 6'b0};
      4'd6:  return {6'b001010, 10'b0};
      4'd7:  return {6'b0, 4'b0001, 2'b00, 2'b10, 2'b00};
      4'd8:  return {6'b0, 4'b0110, 6'b0};
      4'd9:  return {6'b0, 4'b0001, 2'b10, (op == 6'b001000) ? 2'b00 : 2'b11, 2'b00};
      4'd10: return {6'b0, 4'b0010, 6'b0};
      4'd11: return {6'b010000, 4'b0001, 2'b00, 2'b01, 2'b01};
      4'd12: return {6'b100000, 4'b0, 4'b0, 2'b10};
      default: return 16'b0;
    endcase
  endfunction

  logic [3:0] m_st = 4'd0;
  logic [11:0] m_route = 12'd0;
  int m_cnt = 0;
  logic m_done = 1'b0, m_ill = 1'b0, m_bus = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 4'd0; m_route <= 12'd0; m_cnt <= 0;
      m_done <= 1'b0; m_ill <= 1'b0; m_bus <= 1'b0;
    end else begin
      m_done <= 1'b0; m_ill <= 1'b0; m_bus <= 1'b0; m_cnt <= 0;
      if (m_st == 4'd0) m_st <= 4'd1;
      else if ((m_st == 4'd1 || m_st == 4'd4 || m_st == 4'd6) && !memReady) begin
        if (m_cnt == TO - 1) begin
          m_st <= 4'd1;
          m_bus <= 1'b1;
        end else m_cnt <= m_cnt + 1;
      end else if (m_st == 4'd1) m_st <= 4'd2;
      else if (m_st == 4'd2) begin
        m_route <= route(opcode) << 4;
        m_st <= route(opcode) == 12'd0 ? 4'd1 : head(route(opcode));
        m_ill <= route(opcode) == 12'd0;
      end else begin
        m_st <= head(m_route) == 4'd0 ? 4'd1 : head(m_route);
        m_done <= head(m_route) == 4'd0;
        m_route <= m_route << 4;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("state", 32'(state), 32'(m_st));
    chk("controls", 32'(ctl), 32'(exp_ctl(m_st, memReady, opcode)));
    chk("pulses", 32'({instrDone, illegalOp, busError}), 32'({m_done, m_ill, m_bus}));
  end

  task automatic step(input logic mr, input logic [5:0] op);
    @(negedge clk);
    memReady = mr;
    opcode = op;
    #2;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2 chk("reset_all_zero", 32'({ctl, state, instrDone, illegalOp, busError}), 32'd0);
    rst_n = 1'b1;
    #1 chk("idle_after_reset", 32'(state), 32'd0);
    // R-type, memReady high
    step(1'b1, 6'b000000); chk("r_fetch", 32'({state, irWrite, pcWrite}), {26'd0, 4'd1, 2'b11});
    step(1'b1, 6'b000000); chk("r_decode", 32'(state), 32'd2);
    step(1'b1, 6'b000000); chk("r_exec", 32'({state, aluOp}), {26'd0, 4'd7, 2'b10});
    step(1'b1, 6'b000000); chk("r_wb", 32'({state, regWrite, regDst}), {26'd0, 4'd8, 2'b11});
    // ori
    step(1'b1, 6'b001101); chk("r_done", 32'({state, instrDone}), {27'd0, 4'd1, 1'b1});
    step(1'b1, 6'b001101);
    step(1'b1, 6'b001101); chk("ori_exec", 32'({state, aluOp, aluSrcB}), {24'd0, 4'd9, 2'b11, 2'b10});
    step(1'b1, 6'b001101); chk("ori_wb", 32'({state, regWrite, regDst}), {26'd0, 4'd10, 2'b10});
    // lw with three wait cycles in MEM_READ
    step(1'b1, 6'b100011); chk("ori_done", 32'(instrDone), 32'd1);
    step(1'b1, 6'b100011);
    step(1'b1, 6'b100011); chk("lw_addr", 32'(state), 32'd3);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 6'b100011);
      chk("lw_read_hold", 32'({state, memRead, iorD}), {26'd0, 4'd4, 2'b11});
    end
    step(1'b1, 6'b100011); chk("lw_wb", 32'({state, memToReg, regWrite}), {26'd0, 4'd5, 2'b11});
    // beq
    step(1'b1, 6'b000100);
    step(1'b1, 6'b000100);
    step(1'b1, 6'b000100);
    chk("beq", 32'({state, aluOp, pcWriteCond, pcSource}), {23'd0, 4'd11, 2'b01, 1'b1, 2'b01});
    // illegal opcode, then FETCH timeout
    step(1'b1, 6'b111111); chk("beq_done", 32'(instrDone), 32'd1);
    step(1'b1, 6'b111111);
    step(1'b0, 6'b111111); chk("illegal", 32'({state, illegalOp, instrDone}), {26'd0, 4'd1, 2'b10});
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 6'b111111);
      chk("fetch_wait", 32'({state, busError, irWrite, pcWrite}), {25'd0, 4'd1, 3'b000});
    end
    step(1'b0, 6'b101011); chk("bus_error", 32'({state, busError, instrDone}), {26'd0, 4'd1, 2'b10});
    step(1'b0, 6'b101011);
    step(1'b0, 6'b101011);
    step(1'b1, 6'b101011); chk("ready_on_last", 32'({irWrite, busError}), 32'b10);
    step(1'b1, 6'b101011); chk("no_bus_error", 32'({state, busError}), {27'd0, 4'd2, 1'b0});
    // sw interrupted by reset
    step(1'b1, 6'b101011);
    step(1'b0, 6'b101011);
    step(1'b0, 6'b101011); chk("sw_hold", 32'({state, memWrite, iorD}), {26'd0, 4'd6, 2'b11});
    #1 rst_n = 1'b0;
    #1 chk("async_reset", 32'({ctl, state, instrDone, illegalOp, busError}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    memReady = 1'b1;
    opcode = 6'b000010;
    #2 chk("idle_again", 32'(state), 32'd0);
    step(1'b1, 6'b000010); chk("fetch_again", 32'(state), 32'd1);
    // j, addi, full sw, andi, xori, then lw timing out in MEM_READ
    step(1'b1, 6'b000010);
    step(1'b1, 6'b000010); chk("jump", 32'({state, pcWrite, pcSource}), {25'd0, 4'd12, 1'b1, 2'b10});
    for (int i = 0; i < 4; i++) step(1'b1, 6'b001000);
    for (int i = 0; i < 4; i++) step(1'b1, 6'b101011);
    for (int i = 0; i < 4; i++) step(1'b1, 6'b001100);
    for (int i = 0; i < 4; i++) step(1'b1, 6'b001110);
    for (int i = 0; i < 3; i++) step(1'b1, 6'b100011);
    for (int i = 0; i < 4; i++) step(1'b0, 6'b100011);
    step(1'b1, 6'b100011);
    chk("read_timeout", 32'({state, busError, instrDone, regWrite}), {25'd0, 4'd1, 3'b100});
    repeat (3) step(1'b1, 6'b000000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
